silife_max7219_display: RTL
===========================

// Module: silife_max7219_display
// PURPOSE
//   Downstream consumer of the 8x8 silife cell grid. On request, snapshots all
//   64 cell "out" bits and serialises them over SPI to a MAX7219 LED driver,
//   one row per digit register. Sits between the grid and the chip pins.
//   Typically start is pulsed once per generation, after the cells' enable tick.
// PARAMETERS
//   CLK_DIV   2   clk cycles per SCK half-period; legal range >= 1.
// PORTS
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high
//   grid_state  in   64  cell outputs; bit r*8+c = row r, column c (r,c 0..7)
//   brightness  in   4   MAX7219 intensity value, written to register 0x0A
//   start       in   1   one-cycle request to transmit a frame
//   busy        out  1   high from the cycle after an accepted start until done
//   done        out  1   one-cycle pulse when the frame has completed
//   max_cs_n    out  1   MAX7219 LOAD/CS, active low
//   max_sck     out  1   SPI clock, idle low
//   max_mosi    out  1   SPI data, MSB first
// BEHAVIOUR
//   Reset values: busy=0, done=0, max_cs_n=1, max_sck=0, max_mosi=0.
//   Reset also re-arms the init flag. Reset mid-frame aborts at the next edge
//   and returns these pin values.
//   States: IDLE -> LOAD -> WORD (CS_LOW, SHIFT, CS_TRAIL, GAP) repeated -> DONE -> IDLE.
//   - IDLE: start=1 is accepted. Capture grid_state and brightness into a
//     snapshot, then go to LOAD. busy rises next cycle. Later changes to the
//     grid do not affect the frame in flight (no tearing).
//   - start while busy or in DONE: ignored, no queueing.
//   - Word list for the first frame after reset (init flag set), 13 words:
//     0x0900, 0x0B07, 0x0C01, 0x0F00, then the normal frame. Clear the init
//     flag once the last of those 4 words has finished.
//   - Normal frame, 9 words: {0x0A, 4'h0, brightness}, then for r=0..7:
//     {8'(r+1), D}, with D[7]=col0 ... D[0]=col7 of row r from the snapshot.
//   - Word timing (16 bits, address byte first, MSB first):
//     - cs_n goes low at word start.
//     - Each bit has a low phase then a high phase, each CLK_DIV cycles.
//       mosi updates at the start of the low phase; sck rises at the start of
//       the high phase.
//     - After bit 0's high phase: sck low, cs_n stays low CLK_DIV cycles, then
//       cs_n high for a GAP of CLK_DIV cycles.
//     - Word = 34*CLK_DIV cycles. mosi returns to 0 whenever cs_n is high.
//   - DONE: after the last word's GAP, done=1 and busy=0 for one cycle, then IDLE.
//     A start in the cycle after done is accepted normally.
//   - Frame length from the LOAD cycle: normal 1 + 9*34*CLK_DIV cycles;
//     first frame 1 + 13*34*CLK_DIV.
//   - Counters: bit counter 0..15; word index 0..12 (init offset 4 skipped when
//     the flag is clear); divider 0..CLK_DIV-1. No counter wraps outside these ranges.
//   - brightness[3:0] is sent verbatim; the upper data nibble is always 0.
// TESTING
//   1. Reset, start with CLK_DIV=2 -> 13 cs_n low pulses. Decoded words
//      0900,0B07,0C01,0F00,0A0b,01xx..08xx. done arrives 885 cycles after the start edge.
//   2. Second start -> exactly 9 words, no init words. done 613 cycles after start.
//   3. grid_state=64'h0000_0000_0000_0081 (row0 col0 and col7) -> word 0x0181.
//      Rows 1..7 are sent as 0x0200..0x0800.
//   4. Toggle grid_state and pulse start repeatedly mid-frame -> frame data
//      equals the snapshot. Only one done is produced, and no extra frame.
//   5. Assert reset during word 5 -> next cycle cs_n=1, sck=0, mosi=0, busy=0.
//      The following start resends the 4 init words.
//   6. Protocol checker throughout: sck only toggles with cs_n=0. mosi is stable
//      for CLK_DIV cycles around each rising sck. Exactly 16 rising edges per cs_n
//      low window. Repeat with CLK_DIV=1.

Source files
------------

// File: rtl/silife_max7219_display_if.sv
// Host-side handshake and MAX7219 pin bundle for the silife display driver.
interface silife_max7219_display_if;
  logic [63:0] grid_state;
  logic [3:0]  brightness;
  logic        start;
  logic        busy;
  logic        done;
  logic        max_cs_n;
  logic        max_sck;
  logic        max_mosi;

  // Requester side: supplies the grid and the start request.
  modport master (
    output grid_state, brightness, start,
    input  busy, done, max_cs_n, max_sck, max_mosi
  );

  // Display driver side.
  modport slave (
    input  grid_state, brightness, start,
    output busy, done, max_cs_n, max_sck, max_mosi
  );
endinterface

// File: rtl/silife_max7219_display.sv
// Snapshots the 8x8 silife grid on start and streams it to a MAX7219 over SPI,
// one row per digit register, preceded by a one-time chip init after reset.
module silife_max7219_display #(
  parameter int CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  silife_max7219_display_if.slave  bus
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [3:0] LAST_INIT_WORD  = 4'd3;
  localparam logic [3:0] FIRST_DATA_WORD = 4'd4;
  localparam logic [3:0] LAST_WORD       = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_CS_TRAIL, S_GAP, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [3:0]       r_bit, w_bit_nxt;
  logic [3:0]       r_word, w_word_nxt;
  logic             r_init, w_init_nxt;
  logic [63:0]      r_grid;
  logic [3:0]       r_bright;
  logic             r_cs_n, r_sck, r_mosi, r_busy, r_done;
  logic             w_cs_n_nxt, w_sck_nxt, w_mosi_nxt, w_busy_nxt, w_done_nxt;
  logic             w_phase_end;
  logic [15:0]      w_word_data;

  // Word list: 0..3 chip init, 4 intensity, 5..12 rows 0..7 (column 0 is the data MSB).
  function automatic logic [15:0] word_of(input logic [3:0]  idx,
                                          input logic [63:0] grid,
                                          input logic [3:0]  bright);
    logic [2:0] row;
    logic [7:0] cells;
    logic [7:0] data;
    row   = 3'(idx - 4'd5);
    cells = grid[{row, 3'b000} +: 8];
    for (int c = 0; c < 8; c++) data[7-c] = cells[c];
    case (idx)
      4'd0:    word_of = 16'h0900;
      4'd1:    word_of = 16'h0B07;
      4'd2:    word_of = 16'h0C01;
      4'd3:    word_of = 16'h0F00;
      4'd4:    word_of = {8'h0A, 4'h0, bright};
      default: word_of = {4'h0, idx - 4'd4, data};
    endcase
  endfunction

  assign w_phase_end = (r_div == DIV_LAST);

  // Next-state, counter and registered-pin decode for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_word_nxt  = r_word;
    w_init_nxt  = r_init;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_SHIFT_LO;
        w_div_nxt   = '0;
        w_bit_nxt   = 4'd15;
        w_word_nxt  = r_init ? 4'd0 : FIRST_DATA_WORD;
      end
      S_SHIFT_LO: begin
        if (w_phase_end) begin
          w_state_nxt = S_SHIFT_HI;
          w_div_nxt   = '0;
        end else w_div_nxt = r_div + DIV_ONE;
      end
      S_SHIFT_HI: begin
        if (w_phase_end) begin
          w_div_nxt = '0;
          if (r_bit == 4'd0) w_state_nxt = S_CS_TRAIL;
          else begin
            w_bit_nxt   = r_bit - 4'd1;
            w_state_nxt = S_SHIFT_LO;
          end
        end else w_div_nxt = r_div + DIV_ONE;
      end
      S_CS_TRAIL: begin
        if (w_phase_end) begin
          w_state_nxt = S_GAP;
          w_div_nxt   = '0;
        end else w_div_nxt = r_div + DIV_ONE;
      end
      S_GAP: begin
        if (w_phase_end) begin
          w_div_nxt = '0;
          if (r_word == LAST_INIT_WORD) w_init_nxt = 1'b0;
          if (r_word == LAST_WORD) w_state_nxt = S_DONE;
          else begin
            w_word_nxt  = r_word + 4'd1;
            w_bit_nxt   = 4'd15;
            w_state_nxt = S_SHIFT_LO;
          end
        end else w_div_nxt = r_div + DIV_ONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Pins are registered from the next state so they never glitch on decode.
    w_word_data = word_of(w_word_nxt, r_grid, r_bright);
    w_cs_n_nxt  = !(w_state_nxt inside {S_SHIFT_LO, S_SHIFT_HI, S_CS_TRAIL});
    w_sck_nxt   = (w_state_nxt == S_SHIFT_HI);
    case (w_state_nxt)
      S_SHIFT_LO:             w_mosi_nxt = w_word_data[w_bit_nxt];
      S_SHIFT_HI, S_CS_TRAIL: w_mosi_nxt = r_mosi;
      default:                w_mosi_nxt = 1'b0;
    endcase
    w_busy_nxt = !(w_state_nxt inside {S_IDLE, S_DONE});
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State, counters, init flag and output pins.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_init  <= 1'b1;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_word  <= w_word_nxt;
      r_init  <= w_init_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sck   <= w_sck_nxt;
      r_mosi  <= w_mosi_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Frame snapshot taken on an accepted start; later grid changes cannot tear the frame.
  always_ff @(posedge clk) begin
    // NOTE: the snapshot is plain data only read after a capture, so it carries no reset.
    if (r_state == S_IDLE && bus.start) begin
      r_grid   <= bus.grid_state;
      r_bright <= bus.brightness;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.max_cs_n = r_cs_n;
  assign bus.max_sck  = r_sck;
  assign bus.max_mosi = r_mosi;

endmodule
